// File: rtl/ad9517_spi_master_if.sv
// ad9517_spi_master_if
//    Bundles the sequencer handshake and the AD9517 serial-port pins of
//    ad9517_spi_master.
//    Sequencer side : i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data[23:0],
//                     o_spi_rd_data[7:0], o_spi_busy
//    Pin side       : o_spi_cs_n, o_spi_sclk, o_spi_sdo, i_spi_sdi
//                     (+ o_spi_sdio_oe when AD9517_SPI_3WIRE_EN is defined)
//    modport master : view of the serial engine itself
//    modport slave  : view of everything around it (sequencer, pads, device)
// Optional feature macro: AD9517_SPI_3WIRE_EN (3-wire SDIO output enable).
interface ad9517_spi_master_if #(
   parameter int MOSI_DATA_WIDTH = 24,
   parameter int MISO_DATA_WIDTH = 8
);
   logic                       i_spi_wr_cmd;
   logic                       i_spi_rd_cmd;
   logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data;
   logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data;
   logic                       o_spi_busy;
   logic                       o_spi_cs_n;
   logic                       o_spi_sclk;
   logic                       o_spi_sdo;
   logic                       i_spi_sdi;
`ifdef AD9517_SPI_3WIRE_EN
   logic                       o_spi_sdio_oe;

   modport master (
      input  i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_spi_sdi,
      output o_spi_rd_data, o_spi_busy, o_spi_cs_n, o_spi_sclk, o_spi_sdo,
             o_spi_sdio_oe
   );

   modport slave (
      output i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_spi_sdi,
      input  o_spi_rd_data, o_spi_busy, o_spi_cs_n, o_spi_sclk, o_spi_sdo,
             o_spi_sdio_oe
   );
`else
   modport master (
      input  i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_spi_sdi,
      output o_spi_rd_data, o_spi_busy, o_spi_cs_n, o_spi_sclk, o_spi_sdo
   );

   modport slave (
      output i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_spi_sdi,
      input  o_spi_rd_data, o_spi_busy, o_spi_cs_n, o_spi_sclk, o_spi_sdo
   );
`endif
endinterface

// File: rtl/ad9517_spi_master.sv
// ad9517_spi_master
//    Single-word SPI engine for the AD9517 serial port (mode 0). Each command
//    is a 24-bit frame: 16-bit instruction (MSB first) followed by one data
//    byte, written from i_spi_wr_data[23:16] or read from i_spi_sdi.
//    Ports:
//       clk  - sole clock, rising edge
//       rst  - synchronous, active-high reset
//       spi  - ad9517_spi_master_if.master (handshake + serial pins)
//    Parameters:
//       MOSI_DATA_WIDTH - command word width, fixed at 24
//       MISO_DATA_WIDTH - read data width, fixed at 8
//       CLK_DIV         - SCLK half-period in clk cycles, >= 2
//    Optional feature macro: AD9517_SPI_3WIRE_EN adds o_spi_sdio_oe, which
//    turns the shared SDIO pad around for the data phase of a read.
//
//    state | meaning
//    ------+-----------------------------------------------------------
//    IDLE  | CS_n high, waiting for a write or read command
//    SHIFT | CS_n low, 24 SCLK periods, SDO out / SDI sampled
//    HOLD  | SCLK low, CS_n still low for CLK_DIV cycles
//    GAP   | CS_n high for CLK_DIV cycles, busy still high
module ad9517_spi_master #(
   parameter int MOSI_DATA_WIDTH = 24,
   parameter int MISO_DATA_WIDTH = 8,
   parameter int CLK_DIV         = 4
) (
   input  logic                clk,
   input  logic                rst,
   ad9517_spi_master_if.master spi
);

   localparam int              PH_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [4:0]      BIT_LAST = 5'(MOSI_DATA_WIDTH - 1);
   localparam logic [4:0]      BIT_INSTR_LAST = 5'(MOSI_DATA_WIDTH - MISO_DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

   state_t                     state, state_nxt;
   logic [PH_W-1:0]            ph_cnt, ph_cnt_nxt;
   logic [4:0]                 bit_cnt, bit_cnt_nxt;
   logic [MOSI_DATA_WIDTH-1:0] tx_sr, tx_sr_nxt;
   logic [MISO_DATA_WIDTH-1:0] rx_sr, rx_sr_nxt;
   logic [MISO_DATA_WIDTH-1:0] rd_data, rd_data_nxt;
   logic                       rd_flag, rd_flag_nxt;
   logic                       busy, busy_nxt;
   logic                       cs_n, cs_n_nxt;
   logic                       sclk, sclk_nxt;
   logic                       sdo, sdo_nxt;
   logic                       ph_last;
`ifdef AD9517_SPI_3WIRE_EN
   logic                       oe, oe_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ph_cnt  <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         rd_data <= '0;
         rd_flag <= 1'b0;
         busy    <= 1'b0;
         cs_n    <= 1'b1;
         sclk    <= 1'b0;
         sdo     <= 1'b0;
`ifdef AD9517_SPI_3WIRE_EN
         oe      <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         ph_cnt  <= ph_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         tx_sr   <= tx_sr_nxt;
         rx_sr   <= rx_sr_nxt;
         rd_data <= rd_data_nxt;
         rd_flag <= rd_flag_nxt;
         busy    <= busy_nxt;
         cs_n    <= cs_n_nxt;
         sclk    <= sclk_nxt;
         sdo     <= sdo_nxt;
`ifdef AD9517_SPI_3WIRE_EN
         oe      <= oe_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      ph_cnt_nxt  = ph_cnt;
      bit_cnt_nxt = bit_cnt;
      tx_sr_nxt   = tx_sr;
      rx_sr_nxt   = rx_sr;
      rd_data_nxt = rd_data;
      rd_flag_nxt = rd_flag;
      busy_nxt    = busy;
      cs_n_nxt    = cs_n;
      sclk_nxt    = sclk;
      sdo_nxt     = sdo;
`ifdef AD9517_SPI_3WIRE_EN
      oe_nxt      = oe;
`endif
      ph_last     = (ph_cnt == PH_LAST);

      case (state)
         IDLE: begin
            if (spi.i_spi_wr_cmd | spi.i_spi_rd_cmd) begin
               // Read wins a collision; its data phase shifts out zeros.
               state_nxt   = SHIFT;
               rd_flag_nxt = spi.i_spi_rd_cmd;
               tx_sr_nxt   = {spi.i_spi_wr_data[15:0],
                              spi.i_spi_rd_cmd ? 8'h00 : spi.i_spi_wr_data[23:16]};
               sdo_nxt     = spi.i_spi_wr_data[15];
               cs_n_nxt    = 1'b0;
               busy_nxt    = 1'b1;
               sclk_nxt    = 1'b0;
               ph_cnt_nxt  = '0;
               bit_cnt_nxt = '0;
`ifdef AD9517_SPI_3WIRE_EN
               oe_nxt      = 1'b1;
`endif
            end
         end

         SHIFT: begin
            if (ph_last) begin
               ph_cnt_nxt = '0;
               sclk_nxt   = ~sclk;
               if (!sclk) begin
                  // Rising SCLK edge: the device drove SDI on the previous fall.
                  rx_sr_nxt = {rx_sr[MISO_DATA_WIDTH-2:0], spi.i_spi_sdi};
               end else if (bit_cnt == BIT_LAST) begin
                  state_nxt = HOLD;
                  sdo_nxt   = 1'b0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 5'd1;
                  tx_sr_nxt   = {tx_sr[MOSI_DATA_WIDTH-2:0], 1'b0};
                  sdo_nxt     = tx_sr[MOSI_DATA_WIDTH-2];
`ifdef AD9517_SPI_3WIRE_EN
                  // Release SDIO at the start of the read data phase.
                  if (rd_flag && (bit_cnt == BIT_INSTR_LAST)) begin
                     oe_nxt = 1'b0;
                  end
`endif
               end
            end else begin
               ph_cnt_nxt = ph_cnt + 1'b1;
            end
         end

         HOLD: begin
            if (ph_last) begin
               state_nxt  = GAP;
               ph_cnt_nxt = '0;
               cs_n_nxt   = 1'b1;
               if (rd_flag) begin
                  rd_data_nxt = rx_sr;
               end
            end else begin
               ph_cnt_nxt = ph_cnt + 1'b1;
            end
         end

         GAP: begin
            if (ph_last) begin
               state_nxt  = IDLE;
               ph_cnt_nxt = '0;
               busy_nxt   = 1'b0;
`ifdef AD9517_SPI_3WIRE_EN
               oe_nxt     = 1'b0;
`endif
            end else begin
               ph_cnt_nxt = ph_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign spi.o_spi_rd_data = rd_data;
   assign spi.o_spi_busy    = busy;
   assign spi.o_spi_cs_n    = cs_n;
   assign spi.o_spi_sclk    = sclk;
   assign spi.o_spi_sdo     = sdo;
`ifdef AD9517_SPI_3WIRE_EN
   assign spi.o_spi_sdio_oe = oe;
`endif

endmodule

// File: doc/ad9517_spi_master.md
# ad9517_spi_master

- SPI serial engine that executes the single-word read and write commands issued by the AD9517 configuration sequencer. It drives the AD9517 serial port pins: CS_n, SCLK and SDIO/SDO.
- Each command is one 24-bit word: a 16-bit instruction followed by one data byte.
- On a read, the engine returns the byte clocked out by the device and holds it until the next read completes.
- It sits between the sequencer (`spi_wr_cmd`/`spi_rd_cmd`/`spi_wr_data`/`spi_rd_data`/`spi_busy`) and the FPGA pins.

## Interface
- `MOSI_DATA_WIDTH`, 24, command word width; fixed at 24.
- `MISO_DATA_WIDTH`, 8, read data width; fixed at 8.
- `CLK_DIV`, 4, SCLK half-period in `clk` cycles; minimum 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_spi_wr_cmd`  in  1  write request pulse.
- `i_spi_rd_cmd`  in  1  read request pulse.
- `i_spi_wr_data`  in  24  command word:
  - [15:0] = instruction: bit15 R/W, bits 14:13 W1:W0, bits 12:0 address.
  - [23:16] = write data byte.
- `o_spi_rd_data`  out  8  last read byte; reset 0.
- `o_spi_busy`  out  1  high while a frame is in progress; reset 0.
- `o_spi_cs_n`  out  1  chip select, active-low; reset 1.
- `o_spi_sclk`  out  1  serial clock, idles low; reset 0.
- `o_spi_sdo`  out  1  serial data to device; reset 0.
- `i_spi_sdi`  in  1  serial data from device.

## Operation
- FSM states: IDLE, SHIFT, HOLD, GAP.
- **IDLE:**
  - A command is accepted when `i_spi_wr_cmd | i_spi_rd_cmd` is high.
  - At acceptance, `i_spi_wr_data` and the read flag are registered and the FSM goes to SHIFT.
  - If both commands are high in the same cycle, the read wins.
- **Commands while busy:** ignored, not queued. The sequencer waits for `o_spi_busy` low.
- **SHIFT:** 24 bits, MSB first, in this order:
  - instruction [15:8];
  - instruction [7:0];
  - data phase: `i_spi_wr_data[23:16]` for a write, or 8 sampled SDI bits for a read (SDO driven 0 during the read data phase).
- **SCLK and data edges (mode 0):**
  - Each bit is SCLK low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - SDO changes only while SCLK is low (at the start of the low half).
  - SDI is registered on the `clk` edge that drives SCLK high. The device drives on falling edges.
- **HOLD:** SCLK low, CS_n still low, for `CLK_DIV` cycles.
- **GAP:** CS_n high for `CLK_DIV` cycles, then return to IDLE.
- **Read data return:** on entering GAP after a read, the 8-bit shift register is copied to `o_spi_rd_data`. Writes never modify `o_spi_rd_data`.
- **Counters:**
  - bit counter: 5 bits, counts 0..23;
  - phase counter: counts 0..`CLK_DIV`-1, wraps and toggles SCLK.
- **`rst` in any state:**
  - next cycle: IDLE, CS_n=1, SCLK=0, SDO=0, busy=0, `o_spi_rd_data`=0;
  - any frame in progress is aborted with no partial update.

## Timing
- Accept at cycle T0.
- T0+1: `o_spi_busy`=1, CS_n=0, SDO = instruction bit15, SCLK=0.
- First SCLK rising edge at T0+1+`CLK_DIV`.
- Last SCLK falling edge at T0+1+48·`CLK_DIV`.
- CS_n rises at T0+1+49·`CLK_DIV`.
- `o_spi_busy` falls at T0+1+50·`CLK_DIV` (busy high for 50·`CLK_DIV` cycles; 200 at default).
- `o_spi_rd_data` is valid from T0+1+49·`CLK_DIV`, i.e. at least `CLK_DIV` cycles before busy falls.
- Back-to-back: a command in the first cycle busy is low starts a new frame. Minimum CS_n high time is `CLK_DIV`+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `AD9517_SPI_3WIRE_EN`.
- **Defined (3-wire SDIO mode):**
  - Adds port `o_spi_sdio_oe`  out  1, reset 0.
  - `o_spi_sdio_oe` is 1 from T0+1 through the instruction phase.
  - For a read, it drops to 0 at the first data-phase low half (bit 16) and stays 0 until IDLE. Deasserted outside frames.
  - For a write, it is 1 for the whole frame.
  - `i_spi_sdi` comes from the shared SDIO pad buffer.
- **Undefined (4-wire mode):**
  - No `o_spi_sdio_oe` port.
  - SDO is driven for all 24 bits.
  - `i_spi_sdi` is the dedicated SDO pin of the device.

## Test plan
- **Write:** `i_spi_wr_data`=24'h5A0010, 1-cycle `i_spi_wr_cmd`, `CLK_DIV`=4.
  - SDO on rising edges = 0x00, 0x10, 0x5A.
  - busy high exactly 200 cycles; `o_spi_rd_data` unchanged.
- **Read ID:** 24'h008003 read; device model drives 0x53 on falling edges in the data phase.
  - SDO instruction bits = 0x8003.
  - `o_spi_rd_data`=8'h53 before busy falls and held afterwards.
- **Collision:** wr and rd high together in IDLE → read frame executes.
  - A second `i_spi_wr_cmd` during busy produces no extra frame (one CS_n low period only).
- **Back-to-back:** 64 writes each issued the cycle busy falls → 64 CS_n pulses, each CS_n high gap ≥ 5 cycles, every word serialized correctly.
- **Reset mid-frame:** `rst` at bit 10 of a read.
  - Next cycle: CS_n=1, SCLK=0, busy=0, `o_spi_rd_data`=0.
  - A following read returns the correct byte.
- **With `AD9517_SPI_3WIRE_EN`:**
  - read: `o_spi_sdio_oe` 1 for 16 bits, then 0 until end of frame;
  - write: `o_spi_sdio_oe` 1 for all 24 bits.
